iddr_deser: RTL and testbench

- Deserializer and word aligner directly downstream of the IDDRE1 model.
- Consumes the Q1/Q2 bit pair IDDRE1 delivers each C cycle and assembles WIDTH-bit words.
- Supports manual 1-bit slip and an automatic training-pattern alignment FSM.
- Feeds link-layer logic in the Verilator-simulated SelectIO receive path.

---
 rtl/iddr_deser_pkg.sv | 33 +++
 rtl/iddr_deser_align.sv | 117 +++++++++++
 rtl/iddr_deser.sv | 109 ++++++++++
 tb/tb_iddr_deser.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/iddr_deser_pkg.sv
// Shared types and width helpers for the IDDR deserializer / word aligner.
package iddr_deser_pkg;

  // Alignment FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_SLIP  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } align_state_e;

  // Match counter and post-slip word counter widths
  localparam int unsigned MCNT_W = 4;
  localparam int unsigned WCNT_W = 3;

  // Width of the slip offset s (0..width-1)
  function automatic int unsigned slip_w(input int unsigned width);
    return $clog2(width);
  endfunction

  // Width of the pair phase counter (0..width/2-1), never below one bit
  function automatic int unsigned ph_w(input int unsigned width);
    return ((width / 2) > 1) ? $clog2(width / 2) : 1;
  endfunction

  // Width of the slip-attempt counter, able to hold the value width
  function automatic int unsigned tries_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/iddr_deser_align.sv
// Training-pattern alignment FSM: checks words, requests slips, reports lock or failure.
module iddr_deser_align
  import iddr_deser_pkg::*;
#(
  parameter int unsigned           WIDTH           = 8,
  parameter logic [WIDTH-1:0]      TRAIN_PATTERN   = WIDTH'(8'h5C),
  parameter int unsigned           MATCH_COUNT     = 4,
  parameter int unsigned           SLIP_WAIT_WORDS = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             strobe_i,
  input  logic             align_start_i,
  input  logic             bitslip_i,
  output logic             slip_req_o,
  output logic             aligned_o,
  output logic             align_fail_o
);

  localparam int unsigned TW = tries_w(WIDTH);

  align_state_e        state_q;
  logic [MCNT_W-1:0]   mcnt_q;
  logic [TW-1:0]       tries_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic                aligned_q;
  logic                align_fail_q;
  logic                manual_ok_s;

  // Manual slips are only accepted while the FSM is not actively searching;
  // a simultaneous restart always takes priority over either slip source.
  assign manual_ok_s = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAIL);
  assign slip_req_o  = !align_start_i &&
                       ((bitslip_i && manual_ok_s) || ((state_q == ST_SLIP) && en_i));
  assign aligned_o    = aligned_q;
  assign align_fail_o = align_fail_q;

  // FSM state, counters and registered status flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      mcnt_q       <= '0;
      tries_q      <= '0;
      wcnt_q       <= '0;
      aligned_q    <= 1'b0;
      align_fail_q <= 1'b0;
    end else if (align_start_i) begin
      state_q      <= ST_CHECK;
      mcnt_q       <= '0;
      tries_q      <= '0;
      wcnt_q       <= '0;
      aligned_q    <= 1'b0;
      align_fail_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        // Strobe only rises on an EN word cycle, so CHECK/WAIT need no EN gate;
        // gating them would drop a word whose strobe lands on the first stall cycle.
        ST_CHECK: begin
          if (strobe_i) begin
            if (word_i == TRAIN_PATTERN) begin
              mcnt_q <= mcnt_q + 4'd1;
              if ((mcnt_q + 4'd1) == MCNT_W'(MATCH_COUNT)) begin
                state_q   <= ST_DONE;
                aligned_q <= 1'b1;
              end
            end else begin
              mcnt_q  <= '0;
              state_q <= ST_SLIP;
            end
          end
        end
        ST_SLIP: begin
          if (en_i) begin
            tries_q <= tries_q + TW'(1);
            if ((tries_q + TW'(1)) == TW'(WIDTH)) begin
              state_q      <= ST_FAIL;
              align_fail_q <= 1'b1;
            end else if (SLIP_WAIT_WORDS == 0) begin
              state_q <= ST_CHECK;
            end else begin
              state_q <= ST_WAIT;
              wcnt_q  <= '0;
            end
          end
        end
        // Discard the words that straddle the old and new window position
        ST_WAIT: begin
          if (SLIP_WAIT_WORDS == 0) begin
            state_q <= ST_CHECK;
          end else if (strobe_i) begin
            if ((wcnt_q + 3'd1) == WCNT_W'(SLIP_WAIT_WORDS)) begin
              state_q <= ST_CHECK;
              wcnt_q  <= '0;
            end else begin
              wcnt_q <= wcnt_q + 3'd1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        ST_FAIL: begin
          state_q <= ST_FAIL;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/iddr_deser.sv
// Deserializer for the IDDRE1 Q1/Q2 pair stream with a slip-selectable word window.
module iddr_deser
  import iddr_deser_pkg::*;
#(
  parameter int unsigned      WIDTH           = 8,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN   = WIDTH'(8'h5C),
  parameter int unsigned      MATCH_COUNT     = 4,
  parameter int unsigned      SLIP_WAIT_WORDS = 1
) (
  input  logic                       C,
  input  logic                       RB,
  input  logic                       Q1,
  input  logic                       Q2,
  input  logic                       EN,
  input  logic                       BITSLIP,
  input  logic                       ALIGN_START,
  output logic [WIDTH-1:0]           DOUT,
  output logic                       DVALID,
  output logic                       ALIGNED,
  output logic                       ALIGN_FAIL,
  output logic [slip_w(WIDTH)-1:0]   SLIP_CNT
);

  localparam int unsigned     SW      = slip_w(WIDTH);
  localparam int unsigned     PW      = ph_w(WIDTH);
  localparam logic [PW-1:0]   PH_LAST = PW'(WIDTH / 2 - 1);
  localparam logic [SW-1:0]   S_LAST  = SW'(WIDTH - 1);

  // The largest window (s = WIDTH-1) reaches bit 2*WIDTH-2 of the shifted
  // 2*WIDTH-bit view, which only needs the newest 2*WIDTH-2 stored bits.
  logic [2*WIDTH-3:0] hist_q, hist_d;
  logic [2*WIDTH-1:0] hist_shift_s;
  logic [PW-1:0]      ph_q, ph_d;
  logic [SW-1:0]      slip_q, slip_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               dvalid_q, dvalid_d;
  logic               word_cyc_s;
  logic               slip_req_s;

  // Shift in the new pair, advance the phase and capture the word window
  always_comb begin
    hist_shift_s = {hist_q, Q1, Q2};
    word_cyc_s   = EN && (ph_q == PH_LAST);
    hist_d       = hist_q;
    ph_d         = ph_q;
    dout_d       = dout_q;
    dvalid_d     = 1'b0;
    slip_d       = slip_q;
    if (EN) begin
      hist_d = hist_shift_s[2*WIDTH-3:0];
      ph_d   = (ph_q == PH_LAST) ? PW'(0) : (ph_q + PW'(1));
    end else begin
      hist_d = hist_q;
      ph_d   = ph_q;
    end
    if (word_cyc_s) begin
      dout_d   = WIDTH'(hist_shift_s >> slip_q);
      dvalid_d = 1'b1;
    end else begin
      dout_d   = dout_q;
      dvalid_d = 1'b0;
    end
    if (slip_req_s) begin
      slip_d = (slip_q == S_LAST) ? SW'(0) : (slip_q + SW'(1));
    end else begin
      slip_d = slip_q;
    end
  end

  // Datapath registers
  always_ff @(posedge C or negedge RB) begin
    if (!RB) begin
      hist_q   <= '0;
      ph_q     <= '0;
      slip_q   <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      ph_q     <= ph_d;
      slip_q   <= slip_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  iddr_deser_align #(
    .WIDTH           (WIDTH),
    .TRAIN_PATTERN   (TRAIN_PATTERN),
    .MATCH_COUNT     (MATCH_COUNT),
    .SLIP_WAIT_WORDS (SLIP_WAIT_WORDS)
  ) u_align (
    .clk_i         (C),
    .rst_ni        (RB),
    .en_i          (EN),
    .word_i        (dout_q),
    .strobe_i      (dvalid_q),
    .align_start_i (ALIGN_START),
    .bitslip_i     (BITSLIP),
    .slip_req_o    (slip_req_s),
    .aligned_o     (ALIGNED),
    .align_fail_o  (ALIGN_FAIL)
  );

  assign DOUT     = dout_q;
  assign DVALID   = dvalid_q;
  assign SLIP_CNT = slip_q;

endmodule

// File: tb/tb_iddr_deser.sv
// Directed self-checking bench for iddr_deser at WIDTH=8.
module tb_iddr_deser;
  import iddr_deser_pkg::*;

  logic       C = 1'b0;
  logic       RB, Q1, Q2, EN, BITSLIP, ALIGN_START;
  logic [7:0] DOUT;
  logic       DVALID, ALIGNED, ALIGN_FAIL;
  logic [2:0] SLIP_CNT;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] pat;
  int         pidx;
  int         slip_changes;
  logic [2:0] prev_slip;
  logic [7:0] w;

  iddr_deser #(
    .WIDTH(8), .TRAIN_PATTERN(8'h5C), .MATCH_COUNT(4), .SLIP_WAIT_WORDS(1)
  ) dut (
    .C(C), .RB(RB), .Q1(Q1), .Q2(Q2), .EN(EN), .BITSLIP(BITSLIP),
    .ALIGN_START(ALIGN_START), .DOUT(DOUT), .DVALID(DVALID),
    .ALIGNED(ALIGNED), .ALIGN_FAIL(ALIGN_FAIL), .SLIP_CNT(SLIP_CNT)
  );

  // Free-running C clock
  always #5 C = ~C;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One C cycle: drive at negedge, sample 1 time unit after posedge
  task automatic tick(input logic en, input logic bs, input logic as);
    @(negedge C);
    EN = en; BITSLIP = bs; ALIGN_START = as;
    if (en) begin
      Q1   = pat[7 - 2*pidx];
      Q2   = pat[6 - 2*pidx];
      pidx = (pidx + 1) % 4;
    end
    @(posedge C);
    #1;
    if (SLIP_CNT !== prev_slip) slip_changes++;
    prev_slip   = SLIP_CNT;
    BITSLIP     = 1'b0;
    ALIGN_START = 1'b0;
  endtask

  task automatic next_word(output logic [7:0] word);
    bit got = 1'b0;
    word = 8'h00;
    for (int i = 0; i < 16 && !got; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (DVALID) begin
        got  = 1'b1;
        word = DOUT;
      end
    end
    check("word_seen", {15'd0, got}, 16'd1);
  endtask

  task automatic reset_dut();
    RB = 1'b0; EN = 1'b0; BITSLIP = 1'b0; ALIGN_START = 1'b0;
    repeat (2) @(negedge C);
    RB = 1'b1;
    pidx = 0; prev_slip = 3'd0; slip_changes = 0;
  endtask

  initial begin
    RB = 1'b0; EN = 1'b0; BITSLIP = 1'b0; ALIGN_START = 1'b0;
    Q1 = 1'b0; Q2 = 1'b0; pat = 8'h00; pidx = 0;
    slip_changes = 0; prev_slip = 3'd0;
    @(posedge C); #1;
    check("rst_dout",   16'(DOUT), 16'h0000);
    check("rst_dvalid", 16'(DVALID), 16'd0);
    check("rst_slip",   16'(SLIP_CNT), 16'd0);
    check("rst_aligned", 16'(ALIGNED), 16'd0);
    check("rst_fail",   16'(ALIGN_FAIL), 16'd0);

    // Plain deserialization of 0xA5, first word on the 4th EN cycle
    reset_dut();
    pat = 8'hA5;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      check("deser_dvalid", 16'(DVALID), 16'(i % 4 == 3));
      if (i % 4 == 3) check("deser_dout", 16'(DOUT), 16'h00A5);
    end

    // EN stall for 3 cycles mid-word
    tick(1'b1, 1'b0, 1'b0); check("stall_pre_dv", 16'(DVALID), 16'd0);
    tick(1'b1, 1'b0, 1'b0); check("stall_pre_dv", 16'(DVALID), 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      check("stall_dv", 16'(DVALID), 16'd0);
      check("stall_hold", 16'(DOUT), 16'h00A5);
    end
    tick(1'b1, 1'b0, 1'b0); check("stall_post_dv", 16'(DVALID), 16'd0);
    tick(1'b1, 1'b0, 1'b0); check("stall_post_dv", 16'(DVALID), 16'd1);
    check("stall_post_dout", 16'(DOUT), 16'h00A5);
    next_word(w); check("stall_next_dout", 16'(w), 16'h00A5);

    // Manual slip in IDLE: window one bit older gives 0xD2
    tick(1'b1, 1'b1, 1'b0);
    check("bitslip_cnt", 16'(SLIP_CNT), 16'd1);
    next_word(w); check("bitslip_dout0", 16'(w), 16'h00D2);
    next_word(w); check("bitslip_dout1", 16'(w), 16'h00D2);

    // Auto-align: 0xE2 stream needs s=3 to show 0x5C
    reset_dut();
    pat = 8'hE2;
    repeat (8) tick(1'b1, 1'b0, 1'b0);
    slip_changes = 0;
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 400 && !ALIGNED; i++) tick(1'b1, 1'b0, 1'b0);
    check("align_aligned", 16'(ALIGNED), 16'd1);
    check("align_slips", 16'(slip_changes), 16'd3);
    check("align_slip_cnt", 16'(SLIP_CNT), 16'd3);
    check("align_fail_lo", 16'(ALIGN_FAIL), 16'd0);
    next_word(w); check("align_dout", 16'(w), 16'h005C);

    // Asynchronous reset mid-word, then first-word latency
    tick(1'b1, 1'b0, 1'b0);
    #2; RB = 1'b0; EN = 1'b0;
    #1;
    check("arst_dout", 16'(DOUT), 16'h0000);
    check("arst_dvalid", 16'(DVALID), 16'd0);
    check("arst_slip", 16'(SLIP_CNT), 16'd0);
    check("arst_aligned", 16'(ALIGNED), 16'd0);
    @(negedge C);
    RB = 1'b1; pidx = 0; prev_slip = 3'd0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      check("arst_lat_dv", 16'(DVALID), 16'(i == 3));
    end
    check("arst_lat_dout", 16'(DOUT), 16'h00E2);

    // Fail: constant zero never matches, eight slips wrap s back to 0
    reset_dut();
    pat = 8'h00;
    repeat (8) tick(1'b1, 1'b0, 1'b0);
    slip_changes = 0;
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 600 && !ALIGN_FAIL; i++) tick(1'b1, 1'b0, 1'b0);
    check("fail_flag", 16'(ALIGN_FAIL), 16'd1);
    check("fail_slips", 16'(slip_changes), 16'd8);
    check("fail_slip_cnt", 16'(SLIP_CNT), 16'd0);
    check("fail_aligned", 16'(ALIGNED), 16'd0);

    // ALIGN_START with BITSLIP: restart wins, no slip
    tick(1'b1, 1'b1, 1'b1);
    check("coll_slip_cnt", 16'(SLIP_CNT), 16'd0);
    check("coll_fail_clr", 16'(ALIGN_FAIL), 16'd0);
    check("coll_aligned", 16'(ALIGNED), 16'd0);
    check("coll_state", 16'(dut.u_align.state_q), 16'(ST_CHECK));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
